// File: rtl/cornet_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cornet_bus_pkg
// Description : Shared types and constants for the Cornet bus responder.
//               Contains the controller state encoding, the address-region
//               encoding, the reset-vector addresses and the data returned
//               for unmapped reads.
// Revision    : 1.0 - initial release
// ============================================================================
package cornet_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_IO   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RGN_RAM      = 2'd0,
        RGN_VECTOR   = 2'd1,
        RGN_IO       = 2'd2,
        RGN_UNMAPPED = 2'd3
    } region_t;

    localparam logic [15:0] c_VECTOR_ADDR_LO = 16'hFFFC;
    localparam logic [15:0] c_VECTOR_ADDR_HI = 16'hFFFD;
    localparam logic [7:0]  UNMAPPED_DATA    = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/cornet_bus_ram.sv
`default_nettype none
// ============================================================================
// Module      : cornet_bus_ram
// Description : Synchronous single-port byte RAM with a registered read.
//               A write takes priority over a read on the same edge; the read
//               register only changes when a read is enabled, so it holds its
//               value across writes.
// Ports       : clk   - clock
//               we    - write enable
//               re    - read enable (loads rdata on the edge)
//               addr  - byte address, RAM_AW bits
//               wdata - write data
//               rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module cornet_bus_ram #(
    parameter int RAM_AW = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [RAM_AW-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] r_mem [0:(1<<RAM_AW)-1];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end else if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cornet_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : cornet_bus_responder
// Description : Memory-side responder for the Cornet CPU bus. Serves
//               single-cycle read/write strobes from on-chip RAM, a fixed
//               reset-vector window and a forwarded IO page, pacing
//               completion with ready.
// Ports       : clk, reset              - clock, async active-high reset
//               addr, rd_req, wr_en,    - CPU request (strobes one cycle)
//               wr_data
//               rd_data, ready          - CPU response
//               io_addr, io_rd, io_wr,  - IO page request (pulsed)
//               io_wr_data
//               io_rd_data, io_ack      - IO page completion
//               err_clr                 - clears the sticky error flags
//               err_overlap             - strobe while busy / both strobes
//               err_timeout             - IO access got no io_ack in time
// Revision    : 1.0 - initial release
// ============================================================================
module cornet_bus_responder
    import cornet_bus_pkg::*;
#(
    parameter int          RAM_AW       = 12,
    parameter logic [7:0]  IO_PAGE      = 8'hFE,
    parameter logic [15:0] RESET_VECTOR = 16'h0444,
    parameter int          WAIT_STATES  = 0,
    parameter int          IO_TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        rd_req,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        ready,
    output logic [7:0]  io_addr,
    output logic        io_rd,
    output logic        io_wr,
    output logic [7:0]  io_wr_data,
    input  logic [7:0]  io_rd_data,
    input  logic        io_ack,
    input  logic        err_clr,
    output logic        err_overlap,
    output logic        err_timeout
);

    localparam logic [3:0] c_WAIT     = 4'(WAIT_STATES);
    localparam logic [7:0] c_TMO_LAST = 8'(IO_TIMEOUT - 1);

    state_t            r_state, w_state_nxt;
    region_t           w_region, w_ld_region, r_pend_region;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [7:0]        r_tmo, w_tmo_nxt;
    logic [RAM_AW-1:0] r_pend_addr, w_ld_addr;
    logic              r_pend_rd;
    logic [7:0]        r_rd_data, w_rd_data_nxt;
    logic              r_src_ram, w_src_ram_nxt;
    logic [7:0]        r_io_addr, w_io_addr_nxt;
    logic [7:0]        r_io_wr_data, w_io_wr_data_nxt;
    logic              r_io_rd, w_io_rd_nxt;
    logic              r_io_wr, w_io_wr_nxt;
    logic              r_err_overlap, r_err_timeout;
    logic              w_accept, w_ovl_set, w_tmo_hit, w_load;
    logic              w_ram_we, w_ram_re;
    logic [7:0]        w_ram_q;

    // Address decode; the vector window outranks the IO page, which outranks RAM.
    always_comb begin
        if (addr == c_VECTOR_ADDR_LO || addr == c_VECTOR_ADDR_HI) begin
            w_region = RGN_VECTOR;
        end else if (addr[15:8] == IO_PAGE) begin
            w_region = RGN_IO;
        end else if ((addr >> RAM_AW) == 16'd0) begin
            w_region = RGN_RAM;
        end else begin
            w_region = RGN_UNMAPPED;
        end
    end

    assign w_accept  = (r_state == ST_IDLE) && (rd_req || wr_en);
    assign w_ovl_set = ((r_state != ST_IDLE) && (rd_req || wr_en)) ||
                       ((r_state == ST_IDLE) && rd_req && wr_en);

    // Read data is loaded either on the capture edge (no wait states) or on
    // the last wait edge, so the load source follows the controller state.
    assign w_ld_addr   = (r_state == ST_IDLE) ? addr[RAM_AW-1:0] : r_pend_addr;
    assign w_ld_region = (r_state == ST_IDLE) ? w_region : r_pend_region;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_tmo_nxt        = r_tmo;
        w_rd_data_nxt    = r_rd_data;
        w_src_ram_nxt    = r_src_ram;
        w_io_rd_nxt      = 1'b0;
        w_io_wr_nxt      = 1'b0;
        w_io_addr_nxt    = r_io_addr;
        w_io_wr_data_nxt = r_io_wr_data;
        w_ram_we         = 1'b0;
        w_ram_re         = 1'b0;
        w_load           = 1'b0;
        w_tmo_hit        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_region == RGN_IO) begin
                        // A simultaneous read strobe is dropped: write wins.
                        w_io_rd_nxt   = !wr_en;
                        w_io_wr_nxt   = wr_en;
                        w_io_addr_nxt = addr[7:0];
                        if (wr_en) begin
                            w_io_wr_data_nxt = wr_data;
                        end
                        w_tmo_nxt   = 8'd0;
                        w_state_nxt = ST_IO;
                    end else begin
                        w_ram_we = wr_en && (w_region == RGN_RAM);
                        if (c_WAIT == 4'd0) begin
                            w_load = !wr_en;
                        end else begin
                            w_cnt_nxt   = c_WAIT;
                            w_state_nxt = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_load      = r_pend_rd;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_IO: begin
                if (io_ack) begin
                    if (r_pend_rd) begin
                        w_rd_data_nxt = io_rd_data;
                        w_src_ram_nxt = 1'b0;
                    end
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo == c_TMO_LAST) begin
                    if (r_pend_rd) begin
                        w_rd_data_nxt = UNMAPPED_DATA;
                        w_src_ram_nxt = 1'b0;
                    end
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // RAM data lives in the RAM's own read register; rd_data is steered to
        // it so the RAM read costs no extra cycle.
        if (w_load) begin
            unique case (w_ld_region)
                RGN_RAM: begin
                    w_ram_re      = 1'b1;
                    w_src_ram_nxt = 1'b1;
                end
                RGN_VECTOR: begin
                    w_rd_data_nxt = w_ld_addr[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];
                    w_src_ram_nxt = 1'b0;
                end
                default: begin
                    w_rd_data_nxt = UNMAPPED_DATA;
                    w_src_ram_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt         <= 4'd0;
            r_tmo         <= 8'd0;
            r_pend_addr   <= '0;
            r_pend_rd     <= 1'b0;
            r_pend_region <= RGN_RAM;
            r_rd_data     <= 8'h00;
            r_src_ram     <= 1'b0;
            r_io_addr     <= 8'h00;
            r_io_wr_data  <= 8'h00;
            r_io_rd       <= 1'b0;
            r_io_wr       <= 1'b0;
            r_err_overlap <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_tmo         <= w_tmo_nxt;
            r_rd_data     <= w_rd_data_nxt;
            r_src_ram     <= w_src_ram_nxt;
            r_io_addr     <= w_io_addr_nxt;
            r_io_wr_data  <= w_io_wr_data_nxt;
            r_io_rd       <= w_io_rd_nxt;
            r_io_wr       <= w_io_wr_nxt;
            // Clearing and a new error on the same edge: the new error wins.
            r_err_overlap <= (r_err_overlap && !err_clr) || w_ovl_set;
            r_err_timeout <= (r_err_timeout && !err_clr) || w_tmo_hit;
            if (w_accept) begin
                r_pend_addr   <= addr[RAM_AW-1:0];
                r_pend_rd     <= !wr_en;
                r_pend_region <= w_region;
            end
        end
    end

    cornet_bus_ram #(
        .RAM_AW (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .re    (w_ram_re),
        .addr  (w_ld_addr),
        .wdata (wr_data),
        .rdata (w_ram_q)
    );

    assign ready       = (r_state == ST_IDLE);
    assign rd_data     = r_src_ram ? w_ram_q : r_rd_data;
    assign io_addr     = r_io_addr;
    assign io_rd       = r_io_rd;
    assign io_wr       = r_io_wr;
    assign io_wr_data  = r_io_wr_data;
    assign err_overlap = r_err_overlap;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cornet_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cornet_bus_responder
// Description : Scoreboard bench for cornet_bus_responder. Instance 0 has no
//               wait states and exercises the vector window, IO page, timeout
//               and reset recovery; instance 1 has three wait states and
//               exercises RAM pacing and overlap errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cornet_bus_responder;

    typedef struct {
        int         id;
        int         issue;
        bit         chk;
        logic [7:0] data;
        int         low;
    } exp_t;

    logic        clk;
    logic        reset       [2];
    logic [15:0] addr        [2];
    logic        rd_req      [2];
    logic        wr_en       [2];
    logic [7:0]  wr_data     [2];
    logic [7:0]  rd_data     [2];
    logic        ready       [2];
    logic [7:0]  io_addr     [2];
    logic        io_rd       [2];
    logic        io_wr       [2];
    logic [7:0]  io_wr_data  [2];
    logic [7:0]  io_rd_data  [2];
    logic        io_ack      [2];
    logic        err_clr     [2];
    logic        err_overlap [2];
    logic        err_timeout [2];

    int n_vec = 0;
    int n_err = 0;
    int n_id  = 0;
    int cyc   = 0;

    cornet_bus_responder #(
        .RAM_AW(12), .IO_PAGE(8'hFE), .RESET_VECTOR(16'h0444),
        .WAIT_STATES(0), .IO_TIMEOUT(15)
    ) dut0 (
        .clk(clk), .reset(reset[0]), .addr(addr[0]), .rd_req(rd_req[0]),
        .wr_en(wr_en[0]), .wr_data(wr_data[0]), .rd_data(rd_data[0]),
        .ready(ready[0]), .io_addr(io_addr[0]), .io_rd(io_rd[0]),
        .io_wr(io_wr[0]), .io_wr_data(io_wr_data[0]), .io_rd_data(io_rd_data[0]),
        .io_ack(io_ack[0]), .err_clr(err_clr[0]), .err_overlap(err_overlap[0]),
        .err_timeout(err_timeout[0])
    );

    cornet_bus_responder #(
        .RAM_AW(12), .IO_PAGE(8'hFE), .RESET_VECTOR(16'h0444),
        .WAIT_STATES(3), .IO_TIMEOUT(15)
    ) dut3 (
        .clk(clk), .reset(reset[1]), .addr(addr[1]), .rd_req(rd_req[1]),
        .wr_en(wr_en[1]), .wr_data(wr_data[1]), .rd_data(rd_data[1]),
        .ready(ready[1]), .io_addr(io_addr[1]), .io_rd(io_rd[1]),
        .io_wr(io_wr[1]), .io_wr_data(io_wr_data[1]), .io_rd_data(io_rd_data[1]),
        .io_ack(io_ack[1]), .err_clr(err_clr[1]), .err_overlap(err_overlap[1]),
        .err_timeout(err_timeout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitors: one per instance, each owning its expected-response queue.
    for (genvar k = 0; k < 2; k++) begin : g_mon
        exp_t q[$];
        exp_t e;
        int   low = 0;
        always @(negedge clk) begin
            if (q.size() > 0 && cyc > q[0].issue) begin
                if (!ready[k]) begin
                    low++;
                    if (low > 100) begin
                        e = q.pop_front();
                        chk($sformatf("d%0d vec%0d ready stuck low", k, e.id), 16'd1, 16'd0);
                        low = 0;
                    end
                end else begin
                    e = q.pop_front();
                    chk($sformatf("d%0d vec%0d busy cycles", k, e.id), 16'(low), 16'(e.low));
                    if (e.chk) begin
                        chk($sformatf("d%0d vec%0d rd_data", k, e.id), 16'(rd_data[k]), 16'(e.data));
                    end
                    low = 0;
                end
            end
        end
    end

    function automatic int qsize(input int k);
        return (k == 0) ? g_mon[0].q.size() : g_mon[1].q.size();
    endfunction

    // Drives one strobe cycle and records the expected completion.
    task automatic issue(input int k, input logic [15:0] a, input bit rd, input bit wr,
                         input logic [7:0] wd, input bit c, input logic [7:0] d, input int lo);
        exp_t x;
        @(negedge clk);
        addr[k] = a; rd_req[k] = rd; wr_en[k] = wr; wr_data[k] = wd;
        x.id = n_id; x.issue = cyc; x.chk = c; x.data = d; x.low = lo;
        n_id++;
        if (k == 0) g_mon[0].q.push_back(x);
        else        g_mon[1].q.push_back(x);
    endtask

    task automatic release_bus(input int k);
        @(negedge clk);
        rd_req[k] = 1'b0; wr_en[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        for (int i = 0; i < 200 && qsize(k) != 0; i++) @(negedge clk);
        if (qsize(k) != 0) begin
            chk($sformatf("d%0d completion timeout", k), 16'(qsize(k)), 16'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1; addr[k] = 16'h0; rd_req[k] = 1'b0; wr_en[k] = 1'b0;
            wr_data[k] = 8'h0; io_rd_data[k] = 8'h0; io_ack[k] = 1'b0; err_clr[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset[0] = 1'b0; reset[1] = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d reset ready", k), 16'(ready[k]), 16'd1);
            chk($sformatf("d%0d reset rd_data", k), 16'(rd_data[k]), 16'h00);
            chk($sformatf("d%0d reset io strobes", k), {14'd0, io_rd[k], io_wr[k]}, 16'd0);
            chk($sformatf("d%0d reset io_addr/wdata", k), {io_addr[k], io_wr_data[k]}, 16'd0);
            chk($sformatf("d%0d reset errors", k), {14'd0, err_overlap[k], err_timeout[k]}, 16'd0);
        end

        // Instance 0: back-to-back word read of the reset vector, no busy cycles.
        issue(0, 16'hFFFC, 1, 0, 8'h00, 1, 8'h44, 0);
        issue(0, 16'hFFFD, 1, 0, 8'h00, 1, 8'h04, 0);
        release_bus(0);
        wait_idle(0);

        // IO read with io_ack four cycles after the pulse: busy cycles T+1..T+5.
        issue(0, 16'hFE07, 1, 0, 8'h00, 1, 8'hC3, 5);
        release_bus(0);
        chk("io read pulse", 16'(io_rd[0]), 16'd1);
        chk("io read addr", 16'(io_addr[0]), 16'h0007);
        @(negedge clk);
        chk("io read pulse width", {14'd0, io_rd[0], io_wr[0]}, 16'd0);
        repeat (3) @(negedge clk);
        io_ack[0] = 1'b1; io_rd_data[0] = 8'hC3;
        @(negedge clk);
        io_ack[0] = 1'b0; io_rd_data[0] = 8'h00;
        wait_idle(0);

        // IO write that is never acknowledged: 15 busy cycles then timeout.
        issue(0, 16'hFE10, 0, 1, 8'h99, 0, 8'h00, 15);
        release_bus(0);
        chk("io write pulse", 16'(io_wr[0]), 16'd1);
        chk("io write data/addr", {io_wr_data[0], io_addr[0]}, 16'h9910);
        wait_idle(0);
        chk("timeout flag", 16'(err_timeout[0]), 16'd1);

        // Unmapped read, then a RAM write that must leave rd_data untouched.
        issue(0, 16'h2000, 1, 0, 8'h00, 1, 8'hFF, 0);
        release_bus(0);
        wait_idle(0);
        issue(0, 16'h0030, 0, 1, 8'h77, 1, 8'hFF, 0);
        release_bus(0);
        wait_idle(0);

        // Reset during an IO wait, a late io_ack, then a normal RAM read.
        @(negedge clk);
        addr[0] = 16'hFE01; rd_req[0] = 1'b1;
        @(negedge clk);
        rd_req[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("io wait ready low", 16'(ready[0]), 16'd0);
        reset[0] = 1'b1;
        #1;
        chk("reset in io ready", 16'(ready[0]), 16'd1);
        chk("reset in io pulse", {14'd0, io_rd[0], io_wr[0]}, 16'd0);
        chk("reset in io flags", {14'd0, err_overlap[0], err_timeout[0]}, 16'd0);
        @(negedge clk);
        reset[0] = 1'b0;
        @(negedge clk);
        io_ack[0] = 1'b1; io_rd_data[0] = 8'h5C;
        @(negedge clk);
        io_ack[0] = 1'b0;
        chk("late ack ready", 16'(ready[0]), 16'd1);
        chk("late ack rd_data", 16'(rd_data[0]), 16'h00);
        issue(0, 16'h0030, 1, 0, 8'h00, 1, 8'h77, 0);
        release_bus(0);
        wait_idle(0);

        // Instance 1: three wait states on RAM accesses.
        issue(1, 16'h0010, 0, 1, 8'h5A, 0, 8'h00, 3);
        release_bus(1);
        wait_idle(1);
        issue(1, 16'h0010, 1, 0, 8'h00, 1, 8'h5A, 3);
        release_bus(1);
        wait_idle(1);
        chk("no overlap yet", 16'(err_overlap[1]), 16'd0);

        // Both strobes together: write wins, rd_data keeps 0x5A; then a read
        // strobe during WAIT that must be ignored.
        issue(1, 16'h0020, 1, 1, 8'h11, 1, 8'h5A, 3);
        @(negedge clk);
        addr[1] = 16'h0010; rd_req[1] = 1'b1; wr_en[1] = 1'b0;
        release_bus(1);
        wait_idle(1);
        chk("overlap flag", 16'(err_overlap[1]), 16'd1);
        issue(1, 16'h0020, 1, 0, 8'h00, 1, 8'h11, 3);
        release_bus(1);
        wait_idle(1);
        chk("overlap sticky", 16'(err_overlap[1]), 16'd1);
        @(negedge clk);
        err_clr[1] = 1'b1;
        @(negedge clk);
        err_clr[1] = 1'b0;
        chk("overlap cleared", 16'(err_overlap[1]), 16'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cornet_bus_responder.md
# cornet_bus_responder

Memory-side responder for the Cornet CPU bus. It accepts the CPU's single-cycle `rd_req` / `wr_en` strobes and serves them from three sources: on-chip RAM, a fixed reset-vector window, and a forwarded IO page. It paces completion with `ready`. It sits between the CPU and the system memory/peripheral fabric, and lets the CPU be exercised standalone in simulation and on the board.

## Interface
Parameters:
- `RAM_AW`, 12: RAM address width. RAM occupies 0x0000 to 2^RAM_AW-1 (4 KB default).
- `IO_PAGE`, 8'hFE: high address byte of the forwarded IO page (0xFE00-0xFEFF).
- `RESET_VECTOR`, 16'h0444: value returned at 0xFFFC (low byte) and 0xFFFD (high byte).
- `WAIT_STATES`, 0: number of extra `ready`-low cycles for RAM, vector and unmapped accesses (0-15).
- `IO_TIMEOUT`, 15: maximum number of cycles to wait for `io_ack` (1-255).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `addr` in 16: CPU address, valid in the strobe cycle.
- `rd_req` in 1: one-cycle read strobe.
- `wr_en` in 1: one-cycle write strobe.
- `wr_data` in 8: write data, valid with `wr_en`.
- `rd_data` out 8: read data, valid whenever `ready`=1 after a read.
- `ready` out 1: 1 = idle or result valid; 0 = busy.
- `io_addr` out 8: IO register index (`addr[7:0]`).
- `io_rd` out 1: one-cycle IO read pulse.
- `io_wr` out 1: one-cycle IO write pulse.
- `io_wr_data` out 8: IO write data.
- `io_rd_data` in 8: IO read data, valid with `io_ack`.
- `io_ack` in 1: IO completion.
- `err_clr` in 1: synchronous clear of the error flags.
- `err_overlap` out 1: sticky; a strobe arrived while busy, or both strobes arrived together.
- `err_timeout` out 1: sticky; an IO access hit the `IO_TIMEOUT` limit.

## Operation
- States: IDLE, WAIT, IO.
- A strobe is accepted only on an edge where the state is IDLE. This edge is the capture edge; `addr` and `wr_data` are latched on it.
- `wr_en` and `rd_req` both high on the same edge: the write is performed, the read is dropped, and `err_overlap` is set.
- Address decode, in priority order:
  - Vector: 0xFFFC and 0xFFFD. Reads return the vector bytes; writes are dropped.
  - IO page: `addr[15:8]`==`IO_PAGE`.
  - RAM: `addr` < 2^RAM_AW.
  - Anything else is unmapped: reads return 0xFF, writes are dropped.
- RAM, vector and unmapped accesses:
  - RAM writes commit on the capture edge.
  - Read data is registered.
  - `WAIT_STATES`=0: stay in IDLE, keep `ready`=1, and load `rd_data` on the capture edge.
  - `WAIT_STATES`=N>0: go to WAIT with counter=N and drive `ready`=0. When the count expires, load `rd_data`, set `ready`=1 and return to IDLE.
- IO accesses:
  - On the capture edge, pulse `io_rd` or `io_wr` for one cycle, drive `io_addr` and `io_wr_data`, set `ready`=0, and go to IO with the timeout counter cleared.
  - `io_ack` is sampled from the edge after the pulse onward.
  - `io_ack` seen: for a read, `rd_data`<=`io_rd_data`; then `ready`=1 and return to IDLE.
  - `IO_TIMEOUT` cycles pass without `io_ack`: `rd_data`<=0xFF for a read, set `err_timeout`, `ready`=1, return to IDLE.
  - An `io_ack` that arrives while in IDLE is ignored.
- A strobe sampled in WAIT or IO (including the completion edge) is ignored and sets `err_overlap`.
- `err_clr` clears both error flags. If a new error occurs on the same edge, setting wins.
- After a write, `rd_data` holds its previous value.

## Timing
- Reset values: state IDLE, `ready`=1, `rd_data`=0x00, `io_rd`=`io_wr`=0, `io_addr`=0, `io_wr_data`=0, `err_*`=0.
- Reset asserted mid-operation: the operation is abandoned immediately, with no IO pulse or late `ready`. RAM contents are not cleared.
- RAM, vector and unmapped reads: with strobe in cycle T, the capture edge ends T. `ready` is low during cycles T+1 to T+N. Data is valid with `ready`=1 from cycle T+N+1.
- This matches the CPU's rule of sampling on `ready && !rd_req` in the cycle after the strobe. With N=0, `ready` never drops.
- IO: `io_rd`/`io_wr` is high in cycle T+1. `ready` rises in the cycle after the edge that samples `io_ack`.
- Back-to-back accesses: a new strobe is legal in the first cycle in which `ready`=1 again. This supports the CPU's low-byte-then-high-byte word reads.

## Structure
- Package `cornet_bus_pkg`: state enum; region enum (RAM/VECTOR/IO/UNMAPPED); vector addresses 16'hFFFC and 16'hFFFD; constant `UNMAPPED_DATA`=8'hFF.
- Sub-module `cornet_bus_ram`: synchronous single-port RAM with `RAM_AW` address bits, one write port and a registered read. It is the only storage instance.
- Decode, wait counter, IO handshake and error flags live in the top module.

## Test plan
- Word read from 0xFFFC/0xFFFD with `RESET_VECTOR`=0x0444 -> 0x44, then 0x04; `ready` never low when `WAIT_STATES`=0.
- Write 0x5A to 0x0010, then read 0x0010 with `WAIT_STATES`=3 -> `ready` low exactly 3 cycles after each capture edge; read returns 0x5A.
- IO read at 0xFE07, `io_ack` 4 cycles after the pulse with `io_rd_data`=0xC3 -> `io_addr`=0x07, one-cycle `io_rd`, `rd_data`=0xC3, `ready` rises after the ack edge.
- IO write with `io_ack` never asserted, `IO_TIMEOUT`=15 -> `ready` returns after 15 cycles, `err_timeout`=1; a subsequent read of 0x2000 (unmapped) returns 0xFF.
- `rd_req`+`wr_en` together at 0x0020 with data 0x11 -> RAM[0x20]=0x11 and `err_overlap`=1; a strobe during WAIT is ignored and `err_overlap` stays 1 until `err_clr`.
- `reset` asserted during the IO wait -> `ready`=1, `io_rd`=0 immediately; a late `io_ack` is ignored; the next RAM read completes normally.
